adder_response_checker: RTL and testbench
=========================================

# adder_response_checker

Synthesizable response analyzer for the adder units. Accepts the stimulus vector applied to an adder under test together with that adder's outputs, computes the golden sum, and counts vectors and mismatches. Its run/done state machine reports a pass/fail verdict once the full exhaustive vector space has been observed. It is the on-chip checking end for the adder/mux stage, replacing manual waveform inspection of the full-adder stimulus sweep.

## Interface
Parameters:
- `WIDTH`, 1 — operand width of the adder under test.
- `NUM_VECTORS`, 2**(2*WIDTH+1) — vectors required for a complete run (default: exhaustive).

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  single-cycle pulse; begins a run.
- `abort`  in  1  single-cycle pulse; ends a run early.
- `vec_valid`  in  1  A/B/Cin/S/Cout are valid this cycle.
- `vec_a`  in  WIDTH  operand A applied to the DUT.
- `vec_b`  in  WIDTH  operand B applied to the DUT.
- `vec_cin`  in  1  carry-in applied to the DUT.
- `dut_s`  in  WIDTH  DUT sum.
- `dut_cout`  in  1  DUT carry-out.
- `busy`  out  1  state is RUN.
- `done`  out  1  state is DONE.
- `pass`  out  1  run finished cleanly.
- `mismatch`  out  1  registered one-cycle pulse per failing vector.
- `vec_count`  out  2*WIDTH+2  vectors checked this run.
- `err_count`  out  16  mismatches this run, saturating.
- `fail_vec`  out  2*WIDTH+1  {a,b,cin} of first failing vector (macro only).
- `fail_got`  out  WIDTH+1  {cout,s} of first failing vector (macro only).

## Operation
- Golden: expected = vec_a + vec_b + vec_cin, computed WIDTH+1 bits wide, zero-extended. The carry is the MSB. Compared against {dut_cout, dut_s}.
- FSM states:
  - IDLE: reset state.
  - RUN: vectors are accepted and checked.
  - DONE: holds results.
- Transitions:
  - IDLE/DONE + start → RUN. Clears vec_count, err_count, fail_* and pass.
  - RUN + vec_valid → check the vector, vec_count+1. If the new count equals NUM_VECTORS → DONE.
  - RUN + abort → DONE.
  - start while in RUN is ignored.
- pass is set on entering DONE iff err_count==0 and vec_count==NUM_VECTORS. It is held until the next start or reset.
- Vectors with vec_valid=1 are ignored in IDLE and DONE, including the cycle in which start is sampled.
- Gaps in vec_valid during RUN are allowed; there is no timeout.
- abort and the final vector in the same cycle: the vector is checked and counted, then the FSM goes to DONE and pass is evaluated normally.
- err_count saturates at 16'hFFFF. vec_count cannot exceed NUM_VECTORS.

## Timing
- All outputs are registered.
- Reset values: busy=0, done=0, pass=0, mismatch=0, vec_count=0, err_count=0, fail_vec=0, fail_got=0, state=IDLE.
- Latency: a vector sampled at edge N is reflected in vec_count, err_count and mismatch after edge N.
- done and pass assert after the edge that samples the last vector or abort, together with the final counts.
- busy rises the cycle after start is sampled.
- Asserting rst_n low mid-run immediately forces all outputs to reset values, with no clock required. The run is lost.

## Configuration
- Macro `ADDER_CHK_FAILCAPTURE_EN`.
- Defined: fail_vec/fail_got capture the first mismatching vector of a run and hold it until start or reset. Later mismatches do not overwrite it.
- Undefined: the capture registers are not built and fail_vec/fail_got are tied to 0. All other behaviour is identical.

## Test plan
- WIDTH=1: start, then 8 correct vectors {a,b,cin}=000..111 one per cycle → done=1 after the 8th edge, vec_count=8, err_count=0, pass=1, mismatch never pulses.
- WIDTH=1, dut_cout forced 0 on vector 110 (expected {cout,s}=10) → one mismatch pulse, err_count=1, pass=0. With the macro: fail_vec=3'b110, fail_got=2'b00.
- Abort after 5 vectors → done=1, vec_count=5, pass=0. A further vec_valid is ignored and the count stays 5.
- Reset mid-run: rst_n low after 3 vectors → all outputs 0 asynchronously, state IDLE. vectors sent before a new start are ignored.
- Protocol corners:
  - vec_valid gaps of 1–3 cycles leave counts unchanged.
  - A vector in the start cycle is not counted.
  - start during RUN is ignored.
  - abort coincident with the 8th vector → vec_count=8, pass=1.
- WIDTH=4 (NUM_VECTORS=512): exhaustive correct run → pass=1. DUT sum bit 0 stuck-at-1 → err_count=256, pass=0.

Source files
------------

// File: rtl/adder_response_checker.sv
// adder_response_checker
//
// On-chip response analyzer for an adder under test. Every valid vector
// {vec_a, vec_b, vec_cin} is checked against the DUT result
// {dut_cout, dut_s}. The checker counts vectors and mismatches, and
// reports a pass/fail verdict once NUM_VECTORS vectors have been seen or
// the run is aborted.
//
// Build option: define ADDER_CHK_FAILCAPTURE_EN to capture the first
// failing vector of a run on fail_vec/fail_got. Without it both outputs
// are tied to zero.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      one-cycle pulse, begins a run (ignored while running)
//   abort      one-cycle pulse, ends a run early
//   vec_valid  stimulus/response inputs are valid this cycle
//   vec_a      operand A applied to the adder
//   vec_b      operand B applied to the adder
//   vec_cin    carry-in applied to the adder
//   dut_s      adder sum
//   dut_cout   adder carry-out
//   busy       run in progress
//   done       run finished, results held
//   pass       run completed with every vector seen and no mismatch
//   mismatch   one-cycle pulse per failing vector
//   vec_count  vectors checked this run
//   err_count  mismatches this run, saturating at 16'hFFFF
//   fail_vec   {a,b,cin} of the first failing vector
//   fail_got   {cout,s} of the first failing vector
//
// state  | meaning
// -------+------------------------------------------------
// S_IDLE | after reset, waiting for start
// S_RUN  | vectors are accepted and checked
// S_DONE | run finished, counts and verdict held

module adder_response_checker #(
  parameter int WIDTH       = 1,
  parameter int NUM_VECTORS = 2 ** (2 * WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 vec_valid,
  input  logic [WIDTH-1:0]     vec_a,
  input  logic [WIDTH-1:0]     vec_b,
  input  logic                 vec_cin,
  input  logic [WIDTH-1:0]     dut_s,
  input  logic                 dut_cout,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 mismatch,
  output logic [2*WIDTH+1:0]   vec_count,
  output logic [15:0]          err_count,
  output logic [2*WIDTH:0]     fail_vec,
  output logic [WIDTH:0]       fail_got
);

  localparam int CNT_W = 2 * WIDTH + 2;
  localparam logic [CNT_W-1:0] NUM_VEC_C = CNT_W'(NUM_VECTORS);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH:0]     expected;
  logic [WIDTH:0]     got;
  logic               accept;
  logic               vec_bad;
  logic               start_run;
  logic               finish;
  logic [CNT_W-1:0]   count_next;
  logic [15:0]        err_next;

  // Golden sum is one bit wider than the operands; the carry lands in the MSB.
  assign expected = {1'b0, vec_a} + {1'b0, vec_b} + {{WIDTH{1'b0}}, vec_cin};
  assign got      = {dut_cout, dut_s};

  assign accept  = (state == S_RUN) && vec_valid;
  assign vec_bad = accept && (expected != got);

  assign count_next = accept ? (vec_count + CNT_ONE) : vec_count;
  assign err_next   = (vec_bad && (err_count != 16'hFFFF)) ? (err_count + 16'd1) : err_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The final vector and abort may coincide; the vector is still counted
  // because count_next already includes it when the verdict is formed.
  always_comb begin
    state_next = state;
    start_run  = 1'b0;
    finish     = 1'b0;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_next = S_RUN;
          start_run  = 1'b1;
        end
      end
      S_RUN: begin
        if ((accept && (count_next == NUM_VEC_C)) || abort) begin
          state_next = S_DONE;
          finish     = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Status flags follow the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      mismatch  <= 1'b0;
      vec_count <= '0;
      err_count <= '0;
    end else begin
      busy     <= (state_next == S_RUN);
      done     <= (state_next == S_DONE);
      mismatch <= vec_bad;
      if (start_run) begin
        vec_count <= '0;
        err_count <= '0;
        pass      <= 1'b0;
      end else begin
        vec_count <= count_next;
        err_count <= err_next;
        if (finish) begin
          pass <= (err_next == 16'd0) && (count_next == NUM_VEC_C);
        end
      end
    end
  end

`ifdef ADDER_CHK_FAILCAPTURE_EN
  // err_count restarts at zero every run and never wraps, so a zero count
  // identifies the first failing vector without a separate flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_vec <= '0;
      fail_got <= '0;
    end else if (start_run) begin
      fail_vec <= '0;
      fail_got <= '0;
    end else if (vec_bad && (err_count == 16'd0)) begin
      fail_vec <= {vec_a, vec_b, vec_cin};
      fail_got <= got;
    end
  end
`else
  assign fail_vec = '0;
  assign fail_got = '0;
`endif

endmodule

// File: tb/tb_adder_response_checker.sv
module tb_adder_response_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // WIDTH=1 instance
  logic        start, abort, vec_valid, vec_a, vec_b, vec_cin, dut_s, dut_cout;
  logic        busy, done, pass, mismatch;
  logic [3:0]  vec_count;
  logic [15:0] err_count;
  logic [2:0]  fail_vec;
  logic [1:0]  fail_got;

  // WIDTH=4 instance
  logic        start_w4, abort_w4, vec_valid_w4, vec_cin_w4, dut_cout_w4;
  logic [3:0]  vec_a_w4, vec_b_w4, dut_s_w4;
  logic        busy_w4, done_w4, pass_w4, mismatch_w4;
  logic [9:0]  vec_count_w4;
  logic [15:0] err_count_w4;
  logic [8:0]  fail_vec_w4;
  logic [4:0]  fail_got_w4;

  adder_response_checker #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .vec_valid(vec_valid), .vec_a(vec_a), .vec_b(vec_b), .vec_cin(vec_cin),
    .dut_s(dut_s), .dut_cout(dut_cout),
    .busy(busy), .done(done), .pass(pass), .mismatch(mismatch),
    .vec_count(vec_count), .err_count(err_count),
    .fail_vec(fail_vec), .fail_got(fail_got)
  );

  adder_response_checker #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start_w4), .abort(abort_w4),
    .vec_valid(vec_valid_w4), .vec_a(vec_a_w4), .vec_b(vec_b_w4), .vec_cin(vec_cin_w4),
    .dut_s(dut_s_w4), .dut_cout(dut_cout_w4),
    .busy(busy_w4), .done(done_w4), .pass(pass_w4), .mismatch(mismatch_w4),
    .vec_count(vec_count_w4), .err_count(err_count_w4),
    .fail_vec(fail_vec_w4), .fail_got(fail_got_w4)
  );

  int    checks   = 0;
  int    failures = 0;
  string scen     = "init";

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s.%s got=%0h exp=%0h @%0t", scen, tag, got, exp, $time);
    end
  endtask

  // Reference model for the WIDTH=1 instance: a run is a list of counted
  // vectors; the verdict is formed when eight have been seen or on abort.
  bit m_run, m_fin, m_pass, m_mis;
  int m_cnt, m_err, m_fvec, m_fgot;

  task automatic model_reset();
    m_run = 0; m_fin = 0; m_pass = 0; m_mis = 0;
    m_cnt = 0; m_err = 0; m_fvec = 0; m_fgot = 0;
  endtask

  task automatic model_step(input bit st, input bit ab, input bit v, input int vb, input int got);
    int exp;
    exp = ((vb >> 2) & 1) + ((vb >> 1) & 1) + (vb & 1);
    m_mis = 0;
    if (m_run) begin
      if (v) begin
        m_cnt++;
        if (got != exp) begin
          m_mis = 1;
          if (m_err == 0) begin
            m_fvec = vb;
            m_fgot = got;
          end
          if (m_err < 65535) m_err++;
        end
      end
      if ((v && m_cnt == 8) || ab) begin
        m_run  = 0;
        m_fin  = 1;
        m_pass = (m_err == 0) && (m_cnt == 8);
      end
    end else if (st) begin
      m_run = 1; m_fin = 0; m_pass = 0;
      m_cnt = 0; m_err = 0; m_fvec = 0; m_fgot = 0;
    end
  endtask

  task automatic compare1();
    chk("busy", busy, m_run);
    chk("done", done, m_fin);
    chk("pass", pass, m_pass);
    chk("mismatch", mismatch, m_mis);
    chk("vec_count", vec_count, m_cnt);
    chk("err_count", err_count, m_err);
`ifdef ADDER_CHK_FAILCAPTURE_EN
    chk("fail_vec", fail_vec, m_fvec);
    chk("fail_got", fail_got, m_fgot);
`else
    chk("fail_vec", fail_vec, 0);
    chk("fail_got", fail_got, 0);
`endif
  endtask

  // One clock of stimulus on the WIDTH=1 instance. mask corrupts {cout,s}.
  task automatic drive1(input bit st, input bit ab, input bit v, input int vb, input int mask);
    int a, b, c, res;
    a = (vb >> 2) & 1;
    b = (vb >> 1) & 1;
    c = vb & 1;
    res = ((a + b + c) ^ mask) & 3;
    start = st; abort = ab; vec_valid = v;
    vec_a = a[0]; vec_b = b[0]; vec_cin = c[0];
    dut_s = res[0]; dut_cout = res[1];
    @(posedge clk);
    model_step(st, ab, v, vb, res);
    #1;
    compare1();
    start = 0; abort = 0; vec_valid = 0;
  endtask

  task automatic run4(input bit stuck);
    int exp_err;
    exp_err = 0;
    start_w4 = 1;
    @(posedge clk); #1;
    start_w4 = 0;
    chk("w4.busy", busy_w4, 1);
    for (int i = 0; i < 512; i++) begin
      int a, b, c, s;
      a = (i >> 5) & 15;
      b = (i >> 1) & 15;
      c = i & 1;
      s = a + b + c;
      if (stuck) begin
        if ((s & 1) == 0) exp_err++;
        s = s | 1;
      end
      if ($urandom_range(0, 7) == 0) begin
        vec_valid_w4 = 0;
        @(posedge clk); #1;
      end
      vec_valid_w4 = 1;
      vec_a_w4 = a[3:0]; vec_b_w4 = b[3:0]; vec_cin_w4 = c[0];
      dut_s_w4 = s[3:0]; dut_cout_w4 = s[4];
      @(posedge clk); #1;
    end
    vec_valid_w4 = 0;
    chk("w4.done", done_w4, 1);
    chk("w4.busy_end", busy_w4, 0);
    chk("w4.vec_count", vec_count_w4, 512);
    chk("w4.err_count", err_count_w4, exp_err);
    chk("w4.pass", pass_w4, (exp_err == 0));
  endtask

  initial begin
    rst_n = 0;
    start = 0; abort = 0; vec_valid = 0; vec_a = 0; vec_b = 0; vec_cin = 0; dut_s = 0; dut_cout = 0;
    start_w4 = 0; abort_w4 = 0; vec_valid_w4 = 0; vec_a_w4 = 0; vec_b_w4 = 0;
    vec_cin_w4 = 0; dut_s_w4 = 0; dut_cout_w4 = 0;
    model_reset();

    scen = "reset";
    repeat (3) @(posedge clk);
    #1;
    compare1();
    chk("w4.busy", busy_w4, 0);
    chk("w4.vec_count", vec_count_w4, 0);
    @(negedge clk);
    rst_n = 1;

    // Clean exhaustive run; the vector in the start cycle must not count.
    scen = "clean";
    drive1(1, 0, 1, 3, 0);
    for (int i = 0; i < 8; i++) drive1(0, 0, 1, i, 0);

    // Carry-out forced low on vector 110.
    scen = "fault110";
    drive1(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) drive1(0, 0, 1, i, (i == 6) ? 2 : 0);

    // Abort after five vectors; later vectors are ignored.
    scen = "abort5";
    drive1(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive1(0, 0, 1, i, 0);
    drive1(0, 1, 0, 0, 0);
    drive1(0, 0, 1, 5, 0);
    drive1(0, 0, 1, 6, 1);

    // Asynchronous reset mid-run, checked before any further clock edge.
    scen = "async_reset";
    drive1(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive1(0, 0, 1, i, (i == 1) ? 1 : 0);
    #2 rst_n = 0;
    #1;
    model_reset();
    compare1();
    #2 rst_n = 1;
    drive1(0, 0, 1, 1, 0);
    drive1(0, 0, 1, 2, 3);

    // Gaps, start during run, abort together with the eighth vector.
    scen = "corners";
    drive1(1, 0, 1, 5, 0);
    drive1(0, 0, 1, 0, 0);
    for (int g = 0; g < 3; g++) drive1(0, 0, 0, $urandom_range(0, 7), 0);
    drive1(0, 0, 1, 1, 0);
    drive1(0, 0, 0, 0, 0);
    drive1(1, 0, 1, 2, 0);
    for (int i = 3; i < 7; i++) drive1(0, 0, 1, i, 0);
    drive1(0, 0, 0, 0, 0);
    drive1(0, 1, 1, 7, 0);

    // Randomized runs against the model.
    scen = "random";
    for (int r = 0; r < 40; r++) begin
      drive1(1, 0, $urandom_range(0, 1), $urandom_range(0, 7), 0);
      for (int k = 0; k < 200 && m_run; k++) begin
        drive1(($urandom_range(0, 19) == 0),
               ($urandom_range(0, 39) == 0),
               ($urandom_range(0, 9) < 7),
               $urandom_range(0, 7),
               ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 0);
      end
      drive1(0, 0, $urandom_range(0, 1), $urandom_range(0, 7), 0);
    end

    scen = "w4_clean";
    run4(0);
    scen = "w4_stuck_s0";
    run4(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
